// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle minifloat adder sequencer: compare, align (1 bit/cycle), add/sub, normalize, hold result.
// Optional macro FP_ADD_SUB_EN adds op_sub_i (A-B when set); undefined builds an A+B-only block.
module fp_add_seq_ctrl #(
  parameter int MANT_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [MANT_W+4:0] a_i,
  input  logic [MANT_W+4:0] b_i,
`ifdef FP_ADD_SUB_EN
  input  logic              op_sub_i,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [MANT_W+4:0] res_o,
  output logic              ovf_o,
  output logic              uf_o,
  output logic              busy_o
);

  localparam int W     = MANT_W + 5;
  localparam int M     = MANT_W + 2;
  localparam int CNT_W = $clog2(MANT_W + 3);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MANT_W + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Mantissa {carry, hidden, frac}; a zero exponent encodes the value zero.
  function automatic logic [M-1:0] mant_of(input logic [3:0] e, input logic [MANT_W-1:0] f);
    logic [M-1:0] m;
    if (e == 4'd0) begin
      m = {M{1'b0}};
    end else begin
      m = {1'b0, 1'b1, f};
    end
    return m;
  endfunction

  state_t             state_r, state_n;
  logic [3:0]         exp_r, exp_n;
  logic               sign_r, sign_n;
  logic [M-1:0]       big_r, big_n;
  logic [M-1:0]       small_r, small_n;
  logic [CNT_W-1:0]   cnt_r, cnt_n;
  logic               eff_sub_r, eff_sub_n;
  logic [W-1:0]       res_r, res_n;
  logic               ovf_r, ovf_n;
  logic               uf_r, uf_n;
  logic               in_ready_r, out_valid_r, busy_r;

  logic               sign_a_s, sign_b_s;
  logic [3:0]         exp_a_s, exp_b_s;
  logic [MANT_W-1:0]  frac_a_s, frac_b_s;
  logic [4:0]         diff_s, adiff_s;
  logic               a_big_s;
  logic [CNT_W-1:0]   cnt_cap_s;

  // Operand field decode and ordering used at the accept edge.
  always_comb begin
    sign_a_s = a_i[W-1];
    exp_a_s  = a_i[W-2:MANT_W];
    frac_a_s = a_i[MANT_W-1:0];
`ifdef FP_ADD_SUB_EN
    sign_b_s = b_i[W-1] ^ op_sub_i;
`else
    sign_b_s = b_i[W-1];
`endif
    exp_b_s  = b_i[W-2:MANT_W];
    frac_b_s = b_i[MANT_W-1:0];
    diff_s   = {1'b0, exp_a_s} - {1'b0, exp_b_s};
    adiff_s  = diff_s[4] ? (5'd0 - diff_s) : diff_s;
    a_big_s  = ({exp_a_s, frac_a_s} >= {exp_b_s, frac_b_s});
    if (adiff_s > 5'(MANT_W + 2)) begin
      cnt_cap_s = CNT_MAX;
    end else begin
      cnt_cap_s = adiff_s[CNT_W-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_n   = state_r;
    exp_n     = exp_r;
    sign_n    = sign_r;
    big_n     = big_r;
    small_n   = small_r;
    cnt_n     = cnt_r;
    eff_sub_n = eff_sub_r;
    res_n     = res_r;
    ovf_n     = ovf_r;
    uf_n      = uf_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid_i) begin
          eff_sub_n = sign_a_s ^ sign_b_s;
          cnt_n     = cnt_cap_s;
          ovf_n     = 1'b0;
          uf_n      = 1'b0;
          if (a_big_s) begin
            exp_n   = exp_a_s;
            sign_n  = sign_a_s;
            big_n   = mant_of(exp_a_s, frac_a_s);
            small_n = mant_of(exp_b_s, frac_b_s);
          end else begin
            exp_n   = exp_b_s;
            sign_n  = sign_b_s;
            big_n   = mant_of(exp_b_s, frac_b_s);
            small_n = mant_of(exp_a_s, frac_a_s);
          end
          state_n = S_ALIGN;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ALIGN: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          small_n = small_r >> 1;
          cnt_n   = cnt_r - CNT_W'(1);
        end else begin
          state_n = S_ADD;
        end
      end
      S_ADD: begin
        // Ordering at capture guarantees big >= small, so the difference never wraps.
        if (eff_sub_r) begin
          big_n = big_r - small_r;
        end else begin
          big_n = big_r + small_r;
        end
        state_n = S_NORM;
      end
      S_NORM: begin
        if (big_r == {M{1'b0}}) begin
          res_n   = {W{1'b0}};
          state_n = S_DONE;
        end else if (big_r[M-1]) begin
          if (exp_r == 4'hF) begin
            res_n   = {sign_r, 4'hF, {MANT_W{1'b1}}};
            ovf_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            big_n = big_r >> 1;
            exp_n = exp_r + 4'd1;
          end
        end else if (!big_r[M-2]) begin
          if (exp_r == 4'd1) begin
            res_n   = {W{1'b0}};
            uf_n    = 1'b1;
            state_n = S_DONE;
          end else begin
            big_n = big_r << 1;
            exp_n = exp_r - 4'd1;
          end
        end else begin
          res_n   = {sign_r, exp_r, big_r[MANT_W-1:0]};
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_DONE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Datapath registers and handshake flags, the latter decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_r       <= 4'd0;
      sign_r      <= 1'b0;
      big_r       <= {M{1'b0}};
      small_r     <= {M{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      eff_sub_r   <= 1'b0;
      res_r       <= {W{1'b0}};
      ovf_r       <= 1'b0;
      uf_r        <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      exp_r       <= exp_n;
      sign_r      <= sign_n;
      big_r       <= big_n;
      small_r     <= small_n;
      cnt_r       <= cnt_n;
      eff_sub_r   <= eff_sub_n;
      res_r       <= res_n;
      ovf_r       <= ovf_n;
      uf_r        <= uf_n;
      in_ready_r  <= (state_n == S_IDLE);
      out_valid_r <= (state_n == S_DONE);
      busy_r      <= (state_n != S_IDLE);
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign busy_o      = busy_r;
  assign res_o       = res_r;
  assign ovf_o       = ovf_r;
  assign uf_o        = uf_r;

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Scoreboard bench for fp_add_seq_ctrl (MANT_W=3): driver queues expectations, monitor checks outputs.
module tb_fp_add_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
`ifdef FP_ADD_SUB_EN
  logic       op_sub = 1'b0;
`endif
  logic       in_ready, out_valid, ovf, uf, busy;
  logic [7:0] res;

  fp_add_seq_ctrl #(.MANT_W(3)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
`ifdef FP_ADD_SUB_EN
    .op_sub_i    (op_sub),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .res_o       (res),
    .ovf_o       (ovf),
    .uf_o        (uf),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       uf;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   inflight = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation on the first valid cycle, then checks the held result.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        inflight = 1'b0;
      end else if (out_valid) begin
        if (!inflight) begin
          if (q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
          end else begin
            cur = q.pop_front();
            check("res", res, cur.res);
            check("ovf", ovf, cur.ovf);
            check("uf", uf, cur.uf);
            check("latency", cyc - cur.acc, cur.lat);
            inflight = 1'b1;
          end
        end else begin
          check("hold_res", res, cur.res);
          check("hold_in_ready", in_ready, 1'b0);
        end
        if (out_ready) inflight = 1'b0;
      end
    end
  end

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [7:0] er, input logic eo, input logic eu, input int el);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", in_ready, 1'b1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.res = er; e.ovf = eo; e.uf = eu; e.lat = el; e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || inflight) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", q.size() + int'(inflight), 0);
  endtask

  task automatic run(input logic [7:0] ta, input logic [7:0] tb_v,
                     input logic [7:0] er, input logic eo, input logic eu, input int el);
    issue(ta, tb_v, er, eo, eu, el);
    drain();
  endtask

  initial begin
    int n;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_res", res, 8'h00);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    run(8'h38, 8'h38, 8'h40, 1'b0, 1'b0, 4);   // 1.0 + 1.0
    run(8'h3C, 8'h28, 8'h3E, 1'b0, 1'b0, 5);   // 1.5 + 0.25
    run(8'h39, 8'hB8, 8'h20, 1'b0, 1'b0, 6);   // three left shifts
    run(8'h38, 8'hB8, 8'h00, 1'b0, 1'b0, 3);   // exact cancel
    run(8'h40, 8'hB8, 8'h38, 1'b0, 1'b0, 5);   // 2.0 - 1.0
    run(8'h28, 8'hBC, 8'hBA, 1'b0, 1'b0, 5);   // B bigger: 0.25 - 1.5
    run(8'h38, 8'h08, 8'h38, 1'b0, 1'b0, 8);   // shift count clamps
    run(8'h38, 8'h00, 8'h38, 1'b0, 1'b0, 8);   // zero operand
    run(8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0, 3);   // saturate

    // Abort an op in ALIGN with reset; result register held 7F before.
    a = 8'h38; b = 8'h08; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy_clr", busy, 1'b0);
    check("abort_res", res, 8'h00);
    check("abort_flags", {ovf, uf}, 2'b00);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    run(8'h09, 8'h88, 8'h00, 1'b0, 1'b1, 3);   // underflow flush

    // Consumer stalls three cycles in DONE.
    out_ready = 1'b0;
    issue(8'h38, 8'h38, 8'h40, 1'b0, 1'b0, 4);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_valid", out_valid, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_busy", busy, 1'b1);
      check("stall_valid_hold", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    drain();
    check("post_stall_idle", in_ready, 1'b1);

`ifdef FP_ADD_SUB_EN
    op_sub = 1'b1;
    run(8'h38, 8'h38, 8'h00, 1'b0, 1'b0, 3);   // 1.0 - 1.0
    run(8'h38, 8'hB8, 8'h40, 1'b0, 1'b0, 4);   // 1.0 - (-1.0)
    op_sub = 1'b0;
`endif

    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
